// File: rtl/status_flag_unit.sv
// NZCV status register: derives flags from the ALU result, holds sr plus one exception-saved copy.
// Zero-latency bypass on sr_next, sr registered one cycle later; no backpressure, inputs sampled every cycle.
module status_flag_unit #(
  parameter int          DW     = 32,
  parameter logic [3:0]  SR_RST = 4'b0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] alu_result,
  input  logic          a_msb,
  input  logic          b_msb,
  input  logic          alu_carry,
  input  logic          shift_carry,
  input  logic [1:0]    op_kind,
  input  logic          s_bit,
  input  logic          cond_pass,
  input  logic          stall,
  input  logic          flush,
  input  logic          sr_wr,
  input  logic [3:0]    sr_wdata,
  input  logic          exc_save,
  input  logic          exc_restore,
  output logic [3:0]    sr,
  output logic [3:0]    sr_next,
  output logic [3:0]    saved_sr,
  output logic          flags_updated
);

  localparam logic [1:0] OP_LOGIC  = 2'b00;
  localparam logic [1:0] OP_ADD    = 2'b01;
  localparam logic [1:0] OP_SUB    = 2'b10;
  localparam logic [1:0] OP_LSHIFT = 2'b11;

  logic       res_msb;
  logic       flag_n;
  logic       flag_z;
  logic       flag_c;
  logic       flag_v;
  logic       upd;
  logic [3:0] cand;

  assign res_msb = alu_result[DW-1];
  assign flag_n  = res_msb;
  assign flag_z  = (alu_result == '0);

  // Logic-class ops keep C and/or V from the current register, not from sr_next.
  always_comb begin
    flag_c = sr[1];
    flag_v = sr[0];
    case (op_kind)
      OP_LOGIC: begin
        flag_c = sr[1];
        flag_v = sr[0];
      end
      OP_ADD: begin
        flag_c = alu_carry;
        flag_v = (a_msb == b_msb) && (res_msb != a_msb);
      end
      OP_SUB: begin
        flag_c = alu_carry;
        flag_v = (a_msb != b_msb) && (res_msb != a_msb);
      end
      OP_LSHIFT: begin
        flag_c = shift_carry;
        flag_v = sr[0];
      end
      default: begin
        flag_c = sr[1];
        flag_v = sr[0];
      end
    endcase
  end

  assign cand = {flag_n, flag_z, flag_c, flag_v};
  assign upd  = s_bit & cond_pass & ~stall & ~flush;

  always_comb begin
    sr_next = sr;
    if (rst)              sr_next = SR_RST;
    else if (exc_restore) sr_next = saved_sr;
    else if (sr_wr)       sr_next = sr_wdata;
    else if (upd)         sr_next = cand;
  end

  // saved_sr captures the pre-edge sr, so save+restore in one cycle swaps the pair.
  always_ff @(posedge clk) begin
    sr            <= sr_next;
    flags_updated <= ~rst & (exc_restore | sr_wr | upd);
    if (rst)           saved_sr <= SR_RST;
    else if (exc_save) saved_sr <= sr;
  end

endmodule

// File: tb/tb_status_flag_unit.sv
// Directed bench for status_flag_unit: driver queues hand-computed expectations, monitor checks each cycle.
module tb_status_flag_unit;

  logic        clk;
  logic        rst;
  logic [31:0] alu_result;
  logic        a_msb, b_msb, alu_carry, shift_carry;
  logic [1:0]  op_kind;
  logic        s_bit, cond_pass, stall, flush, sr_wr;
  logic [3:0]  sr_wdata;
  logic        exc_save, exc_restore;
  logic [3:0]  sr, sr_next, saved_sr;
  logic        flags_updated;

  status_flag_unit #(.DW(32), .SR_RST(4'b0000)) dut (
    .clk(clk), .rst(rst), .alu_result(alu_result), .a_msb(a_msb), .b_msb(b_msb),
    .alu_carry(alu_carry), .shift_carry(shift_carry), .op_kind(op_kind),
    .s_bit(s_bit), .cond_pass(cond_pass), .stall(stall), .flush(flush),
    .sr_wr(sr_wr), .sr_wdata(sr_wdata), .exc_save(exc_save), .exc_restore(exc_restore),
    .sr(sr), .sr_next(sr_next), .saved_sr(saved_sr), .flags_updated(flags_updated)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    bit         has_next;
    logic [3:0] nxt;
    bit         has_reg;
    string      reg_nm;
    logic [3:0] esr;
    logic [3:0] esaved;
    logic       efu;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  bit         prev_vld = 0;
  string      prev_nm;
  logic [3:0] prev_sr, prev_saved;
  logic       prev_fu;

  task automatic cmp(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b", nm, act, exp);
    end
  endtask

  // Monitor: one scoreboard entry per cycle, checked mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.has_next) cmp({e.nm, ".sr_next"}, sr_next, e.nxt);
        if (e.has_reg) begin
          cmp({e.reg_nm, ".sr"}, sr, e.esr);
          cmp({e.reg_nm, ".saved_sr"}, saved_sr, e.esaved);
          cmp({e.reg_nm, ".flags_updated"}, {3'b000, flags_updated}, {3'b000, e.efu});
        end
      end
    end
  end

  task automatic push(input string nm, input bit has_next, input logic [3:0] nxt,
                      input logic [3:0] esr, input logic [3:0] esaved, input logic efu);
    exp_t e;
    e.nm = nm; e.has_next = has_next; e.nxt = nxt;
    e.has_reg = prev_vld; e.reg_nm = prev_nm;
    e.esr = prev_sr; e.esaved = prev_saved; e.efu = prev_fu;
    q.push_back(e);
    prev_vld = 1; prev_nm = nm;
    prev_sr = esr; prev_saved = esaved; prev_fu = efu;
  endtask

  task automatic idle_inputs();
    rst = 0; alu_result = '0; a_msb = 0; b_msb = 0; alu_carry = 0; shift_carry = 0;
    op_kind = 2'b00; s_bit = 0; cond_pass = 0; stall = 0; flush = 0;
    sr_wr = 0; sr_wdata = '0; exc_save = 0; exc_restore = 0;
  endtask

  // Inputs: result, a, b, alu_carry, shift_carry, op, s, cond, stall, flush, wr, wdata, save, restore.
  // Expected: sr_next this cycle, then sr / saved_sr / flags_updated after the edge.
  task automatic step(input string nm, input logic [31:0] res, input bit a, input bit b,
                      input bit ac, input bit sc, input logic [1:0] op, input bit s, input bit cp,
                      input bit st, input bit fl, input bit wr, input logic [3:0] wd,
                      input bit sv, input bit rs, input logic [3:0] e_next,
                      input logic [3:0] e_sr, input logic [3:0] e_saved, input bit e_fu);
    @(posedge clk); #1;
    rst = 0; alu_result = res; a_msb = a; b_msb = b; alu_carry = ac; shift_carry = sc;
    op_kind = op; s_bit = s; cond_pass = cp; stall = st; flush = fl;
    sr_wr = wr; sr_wdata = wd; exc_save = sv; exc_restore = rs;
    push(nm, 1, e_next, e_sr, e_saved, e_fu);
  endtask

  task automatic reset_step(input string nm, input bit randomize_all);
    @(posedge clk); #1;
    alu_result = $urandom; a_msb = 1'($urandom); b_msb = 1'($urandom);
    alu_carry = 1'($urandom); shift_carry = 1'($urandom); op_kind = 2'($urandom);
    s_bit = 1'($urandom); cond_pass = 1'($urandom); stall = 1'($urandom); flush = 1'($urandom);
    sr_wr = 1'($urandom); sr_wdata = 4'($urandom);
    exc_save = 1'($urandom); exc_restore = 1'($urandom);
    if (!randomize_all) begin
      sr_wr = 1; sr_wdata = 4'b1111; exc_save = 1; exc_restore = 1; s_bit = 1; cond_pass = 1;
    end
    rst = 1;
    push(nm, 1, 4'b0000, 4'b0000, 4'b0000, 1'b0);
  endtask

  initial begin
    int waited;
    idle_inputs();
    reset_step("rst0", 1);
    reset_step("rst1", 1);
    //    name         result        a b ac sc op    s cp st fl wr wd      sv rs  next     sr       saved    fu
    step("idle0",      32'h0,        0,0,0, 0, 2'b00,0,0, 0, 0, 0, 4'h0,   0, 0,  4'b0000, 4'b0000, 4'b0000, 0);
    step("add_ovf",    32'h8000_0000,0,0,0, 0, 2'b01,1,1, 0, 0, 0, 4'h0,   0, 0,  4'b1001, 4'b1001, 4'b0000, 1);
    step("idle1",      32'h0,        0,0,0, 0, 2'b00,0,0, 0, 0, 0, 4'h0,   0, 0,  4'b1001, 4'b1001, 4'b0000, 0);
    step("sub_eq",     32'h0,        1,1,1, 0, 2'b10,1,1, 0, 0, 0, 4'h0,   0, 0,  4'b0110, 4'b0110, 4'b0000, 1);
    step("logic_hold", 32'hFFFF_FFFF,0,0,0, 0, 2'b00,1,1, 0, 0, 0, 4'h0,   0, 0,  4'b1010, 4'b1010, 4'b0000, 1);
    step("gate_s",     32'h0,        1,1,1, 0, 2'b10,0,1, 0, 0, 0, 4'h0,   0, 0,  4'b1010, 4'b1010, 4'b0000, 0);
    step("gate_cond",  32'h0,        1,1,1, 0, 2'b10,1,0, 0, 0, 0, 4'h0,   0, 0,  4'b1010, 4'b1010, 4'b0000, 0);
    step("gate_stall", 32'h0,        1,1,1, 0, 2'b10,1,1, 1, 0, 0, 4'h0,   0, 0,  4'b1010, 4'b1010, 4'b0000, 0);
    step("gate_flush", 32'h0,        1,1,1, 0, 2'b10,1,1, 0, 1, 0, 4'h0,   0, 0,  4'b1010, 4'b1010, 4'b0000, 0);
    step("shift_c",    32'h1,        0,0,0, 1, 2'b11,1,1, 0, 0, 0, 4'h0,   0, 0,  4'b0010, 4'b0010, 4'b0000, 1);
    step("b2b_add",    32'h0,        1,1,1, 0, 2'b01,1,1, 0, 0, 0, 4'h0,   0, 0,  4'b0111, 4'b0111, 4'b0000, 1);
    step("b2b_logic",  32'h8000_0000,0,0,0, 0, 2'b00,1,1, 0, 0, 0, 4'h0,   0, 0,  4'b1011, 4'b1011, 4'b0000, 1);
    step("stall0",     32'h7FFF_FFFF,0,1,0, 0, 2'b10,1,1, 1, 0, 0, 4'h0,   0, 0,  4'b1011, 4'b1011, 4'b0000, 0);
    step("stall1",     32'h7FFF_FFFF,0,1,0, 0, 2'b10,1,1, 1, 0, 0, 4'h0,   0, 0,  4'b1011, 4'b1011, 4'b0000, 0);
    step("stall_rel",  32'h7FFF_FFFF,0,1,0, 0, 2'b10,1,1, 0, 0, 0, 4'h0,   0, 0,  4'b0000, 4'b0000, 4'b0000, 1);
    step("wr_over_upd",32'h8000_0000,0,0,0, 0, 2'b00,1,1, 0, 0, 1, 4'b0101,0, 0,  4'b0101, 4'b0101, 4'b0000, 1);
    step("wr_0011",    32'h0,        0,0,0, 0, 2'b00,0,0, 0, 0, 1, 4'b0011,0, 0,  4'b0011, 4'b0011, 4'b0000, 1);
    step("save",       32'h0,        0,0,0, 0, 2'b00,0,0, 0, 0, 0, 4'h0,   1, 0,  4'b0011, 4'b0011, 4'b0011, 0);
    step("wr_1111",    32'h0,        0,0,0, 0, 2'b00,0,0, 0, 0, 1, 4'b1111,0, 0,  4'b1111, 4'b1111, 4'b0011, 1);
    step("rs_over_wr", 32'h8000_0000,0,0,0, 0, 2'b00,1,1, 0, 0, 1, 4'b0101,0, 1,  4'b0011, 4'b0011, 4'b0011, 1);
    step("wr_1100",    32'h0,        0,0,0, 0, 2'b00,0,0, 0, 0, 1, 4'b1100,0, 0,  4'b1100, 4'b1100, 4'b0011, 1);
    step("swap",       32'h0,        0,0,0, 0, 2'b00,0,0, 0, 0, 0, 4'h0,   1, 1,  4'b0011, 4'b0011, 4'b1100, 1);
    step("rs_ungated", 32'h0,        0,0,0, 0, 2'b00,0,0, 1, 1, 0, 4'h0,   0, 1,  4'b1100, 4'b1100, 4'b1100, 1);
    reset_step("rst_mid", 0);
    step("idle_end",   32'h0,        0,0,0, 0, 2'b00,0,0, 0, 0, 0, 4'h0,   0, 0,  4'b0000, 4'b0000, 4'b0000, 0);
    // Final entry carries only the registered result of the last vector.
    @(posedge clk); #1;
    idle_inputs();
    push("tail", 0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    waited = 0;
    while (q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    if (q.size() > 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/status_flag_unit.md
# status_flag_unit

Producer side of the NZCV condition interface: it derives the N, Z, C and V flags from each executed ALU result and holds them in the architectural status register. It sits at the end of the execute stage. Its registered `sr[3:0]` and same-cycle bypass `sr_next[3:0]` feed the condition-evaluation logic of later instructions. It also keeps one saved copy of the flags, captured on exception entry and restored on exception return.

## Interface
Parameters:
- `DW`, default 32: ALU result width; the sign bit is `DW-1`.
- `SR_RST`, default 4'b0000: reset value of `sr` and `saved_sr`.

Ports (name, direction, width, meaning):
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `alu_result`  in  DW  result of the instruction in execute.
- `a_msb`, `b_msb`  in  1 each  sign bits of ALU operand A and operand B as presented to the adder (B before inversion for subtract).
- `alu_carry`  in  1  adder carry-out; for subtract this is NOT-borrow.
- `shift_carry`  in  1  shifter carry-out.
- `op_kind`  in  2  flag class: 00 logic, 01 add, 10 sub, 11 logic with shifter carry.
- `s_bit`  in  1  the instruction requests a flag update.
- `cond_pass`  in  1  the instruction's condition evaluated true.
- `stall`  in  1  the execute stage is frozen this cycle.
- `flush`  in  1  the instruction in execute is being squashed.
- `sr_wr`, `sr_wdata`  in  1 / 4  direct write of the flags (MSR-style).
- `exc_save`  in  1  exception entry: copy `sr` into `saved_sr`.
- `exc_restore`  in  1  exception return: copy `saved_sr` into `sr`.
- `sr`  out  4  registered flags {N,Z,C,V} = bits [3:0].
- `sr_next`  out  4  combinational next value of `sr`.
- `saved_sr`  out  4  registered saved flags.
- `flags_updated`  out  1  registered pulse; high for one cycle after `sr` changed source.

## Operation
- Candidate flags, computed combinationally with `r = alu_result`:
  - N = r[DW-1].
  - Z = (r == 0).
  - C: 00 → hold `sr[1]`; 01 and 10 → `alu_carry`; 11 → `shift_carry`.
  - V: 00 and 11 → hold `sr[0]`; 01 → (a_msb == b_msb) && (r[DW-1] != a_msb); 10 → (a_msb != b_msb) && (r[DW-1] != a_msb).
- `upd = s_bit & cond_pass & ~stall & ~flush`.
- `sr_next` priority, highest first:
  1. `rst` → SR_RST.
  2. `exc_restore` → `saved_sr`.
  3. `sr_wr` → `sr_wdata`.
  4. `upd` → candidate flags.
  5. otherwise → `sr`.
- `sr` <= `sr_next` on every edge.
- `saved_sr`:
  - `rst` → SR_RST.
  - else `exc_save` → the current registered `sr`, i.e. the pre-edge value, not `sr_next`.
  - else hold.
- `exc_save` and `exc_restore` in the same cycle swap the two registers: `sr` gets the old `saved_sr` and `saved_sr` gets the old `sr`.
- `flags_updated` <= `~rst & (exc_restore | sr_wr | upd)`. It pulses even if the resulting value equals the old one.
- `stall`, `flush` and `cond_pass` gate only the ALU-derived update (case 4); direct write and restore are never gated by them.

## Timing
- Reset values: `sr` = SR_RST, `saved_sr` = SR_RST, `flags_updated` = 0. All three are valid on the first edge after `rst` is sampled high.
- `rst` asserted mid-stream overrides every other input on that edge.
- Update latency: an instruction with `upd` in cycle t is visible on `sr_next` in cycle t (zero latency, for the next instruction's condition bypass) and on `sr` from cycle t+1.
- Back-to-back updates in t and t+1 both commit: `sr` at t+2 reflects the t+1 instruction. Logic-class C/V hold uses `sr` at t+1, which already contains the t update.
- A held `stall` keeps `sr` constant for any number of cycles; the update commits in the first cycle with `stall` = 0 if the other qualifiers still hold.
- No handshake: every input is sampled each cycle, and there are no internal wait states.

## Test plan
- Reset: drive random inputs with `rst`=1 for 2 cycles → `sr`=0000, `saved_sr`=0000, `flags_updated`=0 on the edge after `rst`.
- Add overflow: op_kind=01, a_msb=0, b_msb=0, alu_result=32'h8000_0000, alu_carry=0, s_bit=1, cond_pass=1 → `sr_next`=4'b1001 the same cycle; `sr`=1001 next cycle; `flags_updated`=1 for one cycle.
- Sub equal: op_kind=10, a_msb=b_msb=1, result=0, alu_carry=1 → `sr`=0110. Follow with logic op (00) with result=32'hFFFF_FFFF → `sr`=1010 (C and V held).
- Gating: repeat the sub-equal case with each of s_bit=0, cond_pass=0, stall=1, flush=1 in turn → `sr` unchanged and `flags_updated`=0 in every case.
- Priority: `sr_wr`=1, `sr_wdata`=0101 together with a valid update yielding 1000 → `sr`=0101. Add `exc_restore`=1 with `saved_sr`=0011 → `sr`=0011.
- Swap: `sr`=1100, `saved_sr`=0011, `exc_save`=`exc_restore`=1 for one cycle → `sr`=0011, `saved_sr`=1100.
